bcd_scan_counter: RTL and testbench

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/seg_pkg.sv | 18 +
 rtl/bcd_digit.sv | 32 +++
 rtl/bcd_scan_counter.sv | 74 +++++++
 tb/tb_bcd_scan_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the four-digit BCD counter with multiplexed scan outputs.
package seg_pkg;

  typedef logic [3:0] bcd_t;

  localparam int          NUM_DIGITS       = 4;
  localparam bcd_t        BCD_MAX          = 4'd9;
  localparam int unsigned SCAN_DIV_DEFAULT = 4;

  // One-hot digit select, bit 0 = least significant digit.
  function automatic logic [NUM_DIGITS-1:0] onehot(input logic [1:0] idx);
    logic [NUM_DIGITS-1:0] sel;
    sel = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit, counts up or down one step when enabled, with ripple carry/borrow out.
module bcd_digit
  import seg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output bcd_t value,
  output logic inc_out,
  output logic dec_out
);

  // Carry/borrow out are combinational so a whole chain ripples within one cycle.
  assign inc_out = inc && (value == BCD_MAX);
  assign dec_out = dec && (value == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == BCD_MAX) ? '0 : value + 4'd1;
    end else if (dec) begin
      value <= (value == '0) ? BCD_MAX : value - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with a time-multiplexed, registered 7-segment scan output.
module bcd_scan_counter
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cnt_en,
  input  logic                  up_dn,
  input  logic                  clear,
  output logic                  w,
  output logic                  x,
  output logic                  y,
  output logic                  z,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  carry
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [NUM_DIGITS:0] inc_chain;
  logic [NUM_DIGITS:0] dec_chain;
  bcd_t                digits [NUM_DIGITS];
  logic [15:0]         scan_cnt;
  logic [1:0]          digit_idx;
  logic                wrap;

  // Clear wins over counting: suppressing the chain input also suppresses any wrap.
  assign inc_chain[0] = cnt_en && up_dn && !clear;
  assign dec_chain[0] = cnt_en && !up_dn && !clear;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .inc     (inc_chain[i]),
      .dec     (dec_chain[i]),
      .value   (digits[i]),
      .inc_out (inc_chain[i+1]),
      .dec_out (dec_chain[i+1])
    );
  end

  assign wrap = inc_chain[NUM_DIGITS] || dec_chain[NUM_DIGITS];

  // Free-running scan timer, independent of counting and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + 16'd1;
    end
  end

  // Select and strobe are registered together so they can never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {w, x, y, z} <= '0;
      an           <= 4'b0001;
      carry        <= 1'b0;
    end else begin
      {w, x, y, z} <= digits[digit_idx];
      an           <= onehot(digit_idx);
      carry        <= wrap;
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter: scan sequence, ripple, wrap/carry, clear priority, async reset.
module tb_bcd_scan_counter;

  localparam int unsigned SCAN_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       cnt_en;
  logic       up_dn;
  logic       clear;
  logic       w, x, y, z;
  logic [3:0] an;
  logic       carry;

  int errors = 0;
  int checks = 0;

  bcd_scan_counter #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt_en (cnt_en),
    .up_dn  (up_dn),
    .clear  (clear),
    .w      (w),
    .x      (x),
    .y      (y),
    .z      (z),
    .an     (an),
    .carry  (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       cnt_en;
    logic       up_dn;
    logic       clear;
    logic [3:0] exp_an;
    logic [3:0] exp_bcd;
  } vec_t;

  vec_t scan_tab [17];

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Runs n count steps with cnt_en held, returning how many cycles showed carry high.
  task automatic count(input int n, input logic up, output int carries);
    carries = 0;
    @(negedge clk);
    cnt_en = 1'b1;
    up_dn  = up;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (carry === 1'b1) carries++;
    end
    cnt_en = 1'b0;
  endtask

  // Observes two full scan rounds and assembles the displayed digits d3..d0.
  task automatic read_digits(input string name, input logic [15:0] expected);
    logic [15:0] val;
    int          bad;
    val = 16'hxxxx;
    bad = 0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 8 * SCAN_DIV; c++) begin
      @(negedge clk);
      if ($countones(an) != 1 || {w, x, y, z} > 4'd9) bad++;
      for (int d = 0; d < 4; d++)
        if (an[d]) val[d*4 +: 4] = {w, x, y, z};
    end
    check({name, "_digits"}, val, expected);
    check({name, "_scan_legal"}, 16'(bad), 16'd0);
  endtask

  int c;

  initial begin
    for (int i = 0; i < 17; i++) begin
      scan_tab[i].cnt_en  = 1'b0;
      scan_tab[i].up_dn   = 1'b0;
      scan_tab[i].clear   = 1'b0;
      scan_tab[i].exp_an  = 4'b0001 << ((i / SCAN_DIV) % 4);
      scan_tab[i].exp_bcd = 4'd0;
    end

    rst_n  = 1'b0;
    cnt_en = 1'b0;
    up_dn  = 1'b1;
    clear  = 1'b0;
    #12;
    check("reset_an",    16'(an), 16'h0001);
    check("reset_bcd",   16'({w, x, y, z}), 16'h0000);
    check("reset_carry", 16'(carry), 16'h0000);

    // Idle scan: an advances every SCAN_DIV cycles, display stays zero.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cnt_en = scan_tab[i].cnt_en;
      up_dn  = scan_tab[i].up_dn;
      clear  = scan_tab[i].clear;
      @(negedge clk);
      check($sformatf("scan_an_%0d", i),  16'(an), 16'(scan_tab[i].exp_an));
      check($sformatf("scan_bcd_%0d", i), 16'({w, x, y, z}), 16'(scan_tab[i].exp_bcd));
    end

    // Up ripple 0000 -> 0010.
    count(10, 1'b1, c);
    check("up_ripple_carry", 16'(c), 16'd0);
    read_digits("up_ripple", 16'h0010);

    // Back to 0000, then down-wrap to 9999 and up-wrap to 0000.
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    count(1, 1'b0, c);
    check("down_wrap_carry", 16'(c), 16'd1);
    @(negedge clk);
    check("down_wrap_carry_drop", 16'(carry), 16'd0);
    read_digits("down_wrap", 16'h9999);
    count(1, 1'b1, c);
    check("up_wrap_carry", 16'(c), 16'd1);
    @(negedge clk);
    check("up_wrap_carry_drop", 16'(carry), 16'd0);
    read_digits("up_wrap", 16'h0000);

    // Down ripple 0100 -> 0099.
    count(100, 1'b1, c);
    check("to_0100_carry", 16'(c), 16'd0);
    read_digits("to_0100", 16'h0100);
    count(1, 1'b0, c);
    check("down_ripple_carry", 16'(c), 16'd0);
    read_digits("down_ripple", 16'h0099);

    // Clear beats a simultaneous count.
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    count(5, 1'b1, c);
    read_digits("to_0005", 16'h0005);
    @(negedge clk);
    clear  = 1'b1;
    cnt_en = 1'b1;
    up_dn  = 1'b1;
    @(negedge clk);
    clear  = 1'b0;
    cnt_en = 1'b0;
    check("prio_carry", 16'(carry), 16'd0);
    read_digits("prio", 16'h0000);

    // Clear with a down request at 0000 must not produce a wrap pulse.
    @(negedge clk);
    clear  = 1'b1;
    cnt_en = 1'b1;
    up_dn  = 1'b0;
    @(negedge clk);
    clear  = 1'b0;
    cnt_en = 1'b0;
    check("prio_nowrap_carry", 16'(carry), 16'd0);
    read_digits("prio_nowrap", 16'h0000);

    // Asynchronous reset mid-scan at 1234.
    count(1234, 1'b1, c);
    check("to_1234_carry", 16'(c), 16'd0);
    read_digits("to_1234", 16'h1234);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_an",    16'(an), 16'h0001);
    check("async_rst_bcd",   16'({w, x, y, z}), 16'h0000);
    check("async_rst_carry", 16'(carry), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SCAN_DIV) @(negedge clk);
    check("post_rst_an_hold", 16'(an), 16'h0001);
    @(negedge clk);
    check("post_rst_an_step", 16'(an), 16'h0002);
    read_digits("post_rst", 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
